// File: rtl/execute_unit.sv
// Decode-control, ALU and branch-resolve stage of the single-cycle RISC core.
// The compare flags register is the only state; everything else is combinational.
module execute_unit (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [4:0]  Opcode,
    input  logic        I,
    input  logic [31:0] Op1,
    input  logic [31:0] Op2,
    input  logic [31:0] Immx,
    input  logic [31:0] BranchTarget,
    output logic [31:0] AluResult,
    output logic [4:0]  AluSignal,
    output logic [1:0]  Flags,
    output logic        IsSt,
    output logic        IsLd,
    output logic        IsBeq,
    output logic        IsBgt,
    output logic        IsRet,
    output logic        IsImmediate,
    output logic        IsWb,
    output logic        IsUBranch,
    output logic        IsCall,
    output logic [31:0] BranchPC,
    output logic        IsBranchTaken
);
    localparam logic [4:0] OP_CMP = 5'd5;
    localparam logic [4:0] OP_NOP = 5'd13;

    logic        op_valid;
    logic [31:0] alu_a, alu_b;
    logic [31:0] div_q, mod_r;
    logic [1:0]  flags_q;
    logic        cmp_eq, cmp_gt;

    assign op_valid = (Opcode <= 5'd20);

    always_comb begin
        IsLd        = 1'b0;
        IsSt        = 1'b0;
        IsBeq       = 1'b0;
        IsBgt       = 1'b0;
        IsRet       = 1'b0;
        IsCall      = 1'b0;
        IsUBranch   = 1'b0;
        IsImmediate = 1'b0;
        IsWb        = 1'b0;
        AluSignal   = OP_NOP;
        if (op_valid) begin
            IsLd        = (Opcode == 5'd14);
            IsSt        = (Opcode == 5'd15);
            IsBeq       = (Opcode == 5'd16);
            IsBgt       = (Opcode == 5'd17);
            IsCall      = (Opcode == 5'd19);
            IsRet       = (Opcode == 5'd20);
            IsUBranch   = (Opcode == 5'd18) || (Opcode == 5'd19) || (Opcode == 5'd20);
            IsImmediate = I;
            IsWb        = (Opcode <= 5'd4) || ((Opcode >= 5'd6) && (Opcode <= 5'd12))
                          || (Opcode == 5'd14) || (Opcode == 5'd19);
            if (Opcode <= 5'd12)
                AluSignal = Opcode;
            else if (Opcode == 5'd14 || Opcode == 5'd15)
                AluSignal = 5'd0;
        end
    end

    assign alu_a = Op1;
    assign alu_b = IsImmediate ? Immx : Op2;

    // Divide-by-zero and INT_MIN/-1 are pinned explicitly so the result never
    // depends on the tool's handling of undefined division cases.
    always_comb begin
        div_q = 32'd0;
        mod_r = 32'd0;
        if (alu_b == 32'd0) begin
            div_q = 32'hFFFF_FFFF;
            mod_r = alu_a;
        end else if (alu_a == 32'h8000_0000 && alu_b == 32'hFFFF_FFFF) begin
            div_q = 32'h8000_0000;
            mod_r = 32'd0;
        end else begin
            div_q = $signed(alu_a) / $signed(alu_b);
            mod_r = $signed(alu_a) % $signed(alu_b);
        end
    end

    always_comb begin
        AluResult = 32'd0;
        case (AluSignal)
            5'd0:    AluResult = alu_a + alu_b;
            5'd1:    AluResult = alu_a - alu_b;
            5'd2:    AluResult = alu_a * alu_b;
            5'd3:    AluResult = div_q;
            5'd4:    AluResult = mod_r;
            5'd5:    AluResult = alu_a - alu_b;
            5'd6:    AluResult = alu_a & alu_b;
            5'd7:    AluResult = alu_a | alu_b;
            5'd8:    AluResult = ~alu_b;
            5'd9:    AluResult = alu_b;
            5'd10:   AluResult = alu_a << alu_b[4:0];
            5'd11:   AluResult = alu_a >> alu_b[4:0];
            5'd12:   AluResult = $signed(alu_a) >>> alu_b[4:0];
            default: AluResult = 32'd0;
        endcase
    end

    assign cmp_eq = (alu_a == alu_b);
    assign cmp_gt = ($signed(alu_a) > $signed(alu_b));

    // bit0 = E, bit1 = GT
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset)
            flags_q <= 2'b00;
        else if (Opcode == OP_CMP)
            flags_q <= {cmp_gt, cmp_eq};
    end

    assign Flags         = flags_q;
    assign BranchPC      = IsRet ? Op1 : BranchTarget;
    assign IsBranchTaken = IsUBranch | (IsBeq & flags_q[0]) | (IsBgt & flags_q[1]);

endmodule

// File: tb/tb_execute_unit.sv
// Scoreboard bench for execute_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_execute_unit;
    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [4:0]  Opcode = 5'd13;
    logic        I = 1'b0;
    logic [31:0] Op1 = '0, Op2 = '0, Immx = '0, BranchTarget = '0;
    logic [31:0] AluResult, BranchPC;
    logic [4:0]  AluSignal;
    logic [1:0]  Flags;
    logic        IsSt, IsLd, IsBeq, IsBgt, IsRet, IsImmediate, IsWb, IsUBranch, IsCall;
    logic        IsBranchTaken;

    execute_unit dut (
        .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .I(I), .Op1(Op1), .Op2(Op2),
        .Immx(Immx), .BranchTarget(BranchTarget), .AluResult(AluResult),
        .AluSignal(AluSignal), .Flags(Flags), .IsSt(IsSt), .IsLd(IsLd),
        .IsBeq(IsBeq), .IsBgt(IsBgt), .IsRet(IsRet), .IsImmediate(IsImmediate),
        .IsWb(IsWb), .IsUBranch(IsUBranch), .IsCall(IsCall), .BranchPC(BranchPC),
        .IsBranchTaken(IsBranchTaken)
    );

    always #5 Clk = ~Clk;

    // mask bits: 0 alu, 1 sig, 2 flags, 3 ctrl, 4 bpc, 5 taken
    typedef struct {
        string       name;
        logic [5:0]  mask;
        logic [31:0] alu;
        logic [4:0]  sig;
        logic [1:0]  flags;
        logic [8:0]  ctrl;
        logic [31:0] bpc;
        logic        taken;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // ctrl order: {st, ld, beq, bgt, ret, imm, wb, ubr, call}
    function automatic logic [8:0] ctl(input logic st, ld, beq, bgt, ret, imm, wb, ubr, call);
        return {st, ld, beq, bgt, ret, imm, wb, ubr, call};
    endfunction

    function automatic exp_t mk(input string nm, input logic [5:0] m, input logic [31:0] alu,
                                input logic [4:0] sig, input logic [1:0] fl, input logic [8:0] c,
                                input logic [31:0] bpc, input logic tk);
        exp_t e;
        e.name = nm; e.mask = m; e.alu = alu; e.sig = sig; e.flags = fl;
        e.ctrl = c; e.bpc = bpc; e.taken = tk;
        return e;
    endfunction

    task automatic apply(input logic rst, input logic [4:0] op, input logic imm,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ix, input logic [31:0] bt, input exp_t e);
        @(posedge Clk);
        #1;
        Reset = rst; Opcode = op; I = imm; Op1 = a; Op2 = b; Immx = ix; BranchTarget = bt;
        q.push_back(e);
    endtask

    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [8:0] c;
            e = q.pop_front();
            c = {IsSt, IsLd, IsBeq, IsBgt, IsRet, IsImmediate, IsWb, IsUBranch, IsCall};
            if (e.mask[0]) begin
                total++;
                if (AluResult !== e.alu) begin
                    bad++; $display("FAIL %s alu: got %h want %h", e.name, AluResult, e.alu);
                end
            end
            if (e.mask[1]) begin
                total++;
                if (AluSignal !== e.sig) begin
                    bad++; $display("FAIL %s sig: got %0d want %0d", e.name, AluSignal, e.sig);
                end
            end
            if (e.mask[2]) begin
                total++;
                if (Flags !== e.flags) begin
                    bad++; $display("FAIL %s flags: got %b want %b", e.name, Flags, e.flags);
                end
            end
            if (e.mask[3]) begin
                total++;
                if (c !== e.ctrl) begin
                    bad++; $display("FAIL %s ctrl: got %b want %b", e.name, c, e.ctrl);
                end
            end
            if (e.mask[4]) begin
                total++;
                if (BranchPC !== e.bpc) begin
                    bad++; $display("FAIL %s bpc: got %h want %h", e.name, BranchPC, e.bpc);
                end
            end
            if (e.mask[5]) begin
                total++;
                if (IsBranchTaken !== e.taken) begin
                    bad++; $display("FAIL %s taken: got %b want %b", e.name, IsBranchTaken, e.taken);
                end
            end
        end
    end

    localparam logic [5:0] ALL = 6'b111111;
    localparam logic [5:0] NOFL = 6'b111011;

    initial begin
        int budget;
        // held in reset
        apply(1'b0, 5'd16, 1'b0, 0, 0, 0, 32'h40,
              mk("rst_beq", ALL, 0, 13, 2'b00, ctl(0,0,1,0,0,0,0,0,0), 32'h40, 0));
        apply(1'b1, 5'd16, 1'b0, 0, 0, 0, 32'h40,
              mk("post_rst_beq", ALL, 0, 13, 2'b00, ctl(0,0,1,0,0,0,0,0,0), 32'h40, 0));
        // cmp equal, flags update at next edge
        apply(1'b1, 5'd5, 1'b1, 5, 9, 5, 0,
              mk("cmp_eq", ALL, 0, 5, 2'b00, ctl(0,0,0,0,0,1,0,0,0), 0, 0));
        apply(1'b1, 5'd16, 1'b0, 0, 0, 0, 32'h100,
              mk("beq_taken", ALL, 0, 13, 2'b01, ctl(0,0,1,0,0,0,0,0,0), 32'h100, 1));
        apply(1'b1, 5'd17, 1'b0, 0, 0, 0, 32'h100,
              mk("bgt_nt", ALL, 0, 13, 2'b01, ctl(0,0,0,1,0,0,0,0,0), 32'h100, 0));
        // signed compare -1 vs 1, then swapped
        apply(1'b1, 5'd5, 1'b0, 32'hFFFF_FFFF, 1, 0, 0,
              mk("cmp_m1_1", ALL, 32'hFFFF_FFFE, 5, 2'b01, ctl(0,0,0,0,0,0,0,0,0), 0, 0));
        apply(1'b1, 5'd17, 1'b0, 0, 0, 0, 32'h80,
              mk("bgt_m1_1", ALL, 0, 13, 2'b00, ctl(0,0,0,1,0,0,0,0,0), 32'h80, 0));
        apply(1'b1, 5'd5, 1'b0, 1, 32'hFFFF_FFFF, 0, 0,
              mk("cmp_1_m1", ALL, 2, 5, 2'b00, ctl(0,0,0,0,0,0,0,0,0), 0, 0));
        apply(1'b1, 5'd17, 1'b0, 0, 0, 0, 32'h80,
              mk("bgt_1_m1", ALL, 0, 13, 2'b10, ctl(0,0,0,1,0,0,0,0,0), 32'h80, 1));
        // ALU sweep
        apply(1'b1, 5'd0, 1'b0, 7, 8, 0, 0,
              mk("add", NOFL, 15, 0, 0, ctl(0,0,0,0,0,0,1,0,0), 0, 0));
        apply(1'b1, 5'd1, 1'b0, 3, 5, 0, 0,
              mk("sub", NOFL, 32'hFFFF_FFFE, 1, 0, ctl(0,0,0,0,0,0,1,0,0), 0, 0));
        apply(1'b1, 5'd2, 1'b0, 32'hFFFF_FFFD, 7, 0, 0,
              mk("mul", NOFL, 32'hFFFF_FFEB, 2, 0, ctl(0,0,0,0,0,0,1,0,0), 0, 0));
        apply(1'b1, 5'd3, 1'b0, 32'hFFFF_FFF9, 2, 0, 0,
              mk("div_neg", NOFL, 32'hFFFF_FFFD, 3, 0, ctl(0,0,0,0,0,0,1,0,0), 0, 0));
        apply(1'b1, 5'd4, 1'b0, 32'hFFFF_FFF9, 2, 0, 0,
              mk("mod_neg", NOFL, 32'hFFFF_FFFF, 4, 0, ctl(0,0,0,0,0,0,1,0,0), 0, 0));
        apply(1'b1, 5'd3, 1'b0, 5, 0, 0, 0,
              mk("div_zero", NOFL, 32'hFFFF_FFFF, 3, 0, ctl(0,0,0,0,0,0,1,0,0), 0, 0));
        apply(1'b1, 5'd4, 1'b0, 5, 0, 0, 0,
              mk("mod_zero", NOFL, 5, 4, 0, ctl(0,0,0,0,0,0,1,0,0), 0, 0));
        apply(1'b1, 5'd3, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0,
              mk("div_ovf", NOFL, 32'h8000_0000, 3, 0, ctl(0,0,0,0,0,0,1,0,0), 0, 0));
        apply(1'b1, 5'd4, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0,
              mk("mod_ovf", NOFL, 0, 4, 0, ctl(0,0,0,0,0,0,1,0,0), 0, 0));
        apply(1'b1, 5'd6, 1'b0, 32'hF0F0, 32'h0FF0, 0, 0,
              mk("and", NOFL, 32'h00F0, 6, 0, ctl(0,0,0,0,0,0,1,0,0), 0, 0));
        apply(1'b1, 5'd7, 1'b0, 32'hF0F0, 32'h0FF0, 0, 0,
              mk("or", NOFL, 32'hFFF0, 7, 0, ctl(0,0,0,0,0,0,1,0,0), 0, 0));
        apply(1'b1, 5'd8, 1'b0, 32'h1234, 0, 0, 0,
              mk("not", NOFL, 32'hFFFF_FFFF, 8, 0, ctl(0,0,0,0,0,0,1,0,0), 0, 0));
        apply(1'b1, 5'd9, 1'b1, 0, 32'h55, 32'h1234, 0,
              mk("mov_imm", NOFL, 32'h1234, 9, 0, ctl(0,0,0,0,0,1,1,0,0), 0, 0));
        apply(1'b1, 5'd10, 1'b0, 1, 32'h23, 0, 0,
              mk("lsl_mask", NOFL, 8, 10, 0, ctl(0,0,0,0,0,0,1,0,0), 0, 0));
        apply(1'b1, 5'd11, 1'b1, 32'h8000_0000, 0, 4, 0,
              mk("lsr", NOFL, 32'h0800_0000, 11, 0, ctl(0,0,0,0,0,1,1,0,0), 0, 0));
        apply(1'b1, 5'd12, 1'b1, 32'h8000_0000, 0, 4, 0,
              mk("asr", NOFL, 32'hF800_0000, 12, 0, ctl(0,0,0,0,0,1,1,0,0), 0, 0));
        // control decode
        apply(1'b1, 5'd14, 1'b1, 32'h100, 0, 8, 0,
              mk("ld", NOFL, 32'h108, 0, 0, ctl(0,1,0,0,0,1,1,0,0), 0, 0));
        apply(1'b1, 5'd15, 1'b1, 32'h100, 0, 8, 0,
              mk("st", NOFL, 32'h108, 0, 0, ctl(1,0,0,0,0,1,0,0,0), 0, 0));
        apply(1'b1, 5'd13, 1'b0, 5, 6, 0, 0,
              mk("nop", NOFL, 0, 13, 0, ctl(0,0,0,0,0,0,0,0,0), 0, 0));
        apply(1'b1, 5'd18, 1'b0, 0, 0, 0, 32'h180,
              mk("b", NOFL, 0, 13, 0, ctl(0,0,0,0,0,0,0,1,0), 32'h180, 1));
        apply(1'b1, 5'd19, 1'b0, 0, 0, 0, 32'h200,
              mk("call", NOFL, 0, 13, 0, ctl(0,0,0,0,0,0,1,1,1), 32'h200, 1));
        apply(1'b1, 5'd20, 1'b0, 32'h24, 0, 0, 32'h300,
              mk("ret", NOFL, 0, 13, 0, ctl(0,0,0,0,1,0,0,1,0), 32'h24, 1));
        apply(1'b1, 5'd25, 1'b1, 5, 0, 3, 32'h44,
              mk("op25", ALL, 0, 13, 2'b10, ctl(0,0,0,0,0,0,0,0,0), 32'h44, 0));
        // async reset between cmp and beq; cmp under reset must not latch
        apply(1'b1, 5'd5, 1'b0, 9, 9, 0, 0,
              mk("cmp_pre_rst", ALL, 0, 5, 2'b10, ctl(0,0,0,0,0,0,0,0,0), 0, 0));
        apply(1'b0, 5'd16, 1'b0, 0, 0, 0, 32'h500,
              mk("beq_in_rst", ALL, 0, 13, 2'b00, ctl(0,0,1,0,0,0,0,0,0), 32'h500, 0));
        apply(1'b0, 5'd5, 1'b0, 9, 9, 0, 0,
              mk("cmp_in_rst", ALL, 0, 5, 2'b00, ctl(0,0,0,0,0,0,0,0,0), 0, 0));
        apply(1'b1, 5'd16, 1'b0, 0, 0, 0, 32'h500,
              mk("beq_after_rst", ALL, 0, 13, 2'b00, ctl(0,0,1,0,0,0,0,0,0), 32'h500, 0));

        budget = 0;
        while (q.size() > 0 && budget < 100) begin
            @(posedge Clk);
            budget++;
        end
        if (q.size() > 0) begin
            total++; bad++;
            $display("FAIL drain: %0d left want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
